mmss_countdown: RTL and testbench
=================================

# mmss_countdown

Minutes/seconds countdown timer that consumes the slow square wave produced by the one-second clock generator. It synchronises that wave into the `mclk` domain, turns each rising edge into a single-cycle tick, and decrements a BCD MM:SS count. While counting, it drives the generator's `Enable`. Its outputs feed the seven-segment display driver and the alarm/LED logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `tick_in` (minimum 2).
- `mclk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick_in`, in, 1: 1 Hz square wave (`CLKout` of the one-second generator); asynchronous to the logic.
- `load`, in, 1: one-cycle pulse; latches `preset_mm`/`preset_ss` as the new preset and count.
- `start`, in, 1: one-cycle pulse; begins or resumes counting.
- `stop`, in, 1: one-cycle pulse; pauses counting.
- `preset_mm`, in, 8: BCD minutes 00–99.
- `preset_ss`, in, 8: BCD seconds 00–59.
- `min_bcd`, out, 8: current minutes, BCD.
- `sec_bcd`, out, 8: current seconds, BCD.
- `tick_en`, out, 1: enable to the one-second generator; high in RUN only.
- `running`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `expired`, out, 1: one-cycle pulse when the count reaches 00:00.
- `load_err`, out, 1: one-cycle pulse when a load is rejected.

## Operation
- **States:** IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- **Priority** within a cycle: `load` > `stop` > `start` > tick.
- **`load`** (any state):
  - Preset valid: count and internal preset register take the preset; go to IDLE.
  - Preset invalid (any nibble > 9, or `preset_ss` tens > 5): `load_err` pulses; count, preset and state are unchanged.
- **`start`:**
  - IDLE or PAUSE, count ≠ 00:00: go to RUN.
  - Count = 00:00: ignored.
  - DONE or RUN: ignored.
- **`stop`:** RUN goes to PAUSE; ignored in all other states.
- **Tick in RUN:** decrement the count by one second.
  - `sec_bcd` units 0 → 9 with a tens borrow.
  - `sec_bcd` 00 → 59 with a minutes borrow.
  - `min_bcd` follows the same BCD borrow rules; it never goes below 00.
- **Decrement from 00:01:** count becomes 00:00, `expired` pulses, state goes to DONE.
- **Ticks outside RUN:** discarded and not queued. A tick in the same cycle as `stop` is discarded.
- **Leaving DONE:** only via `load`.
- **Arithmetic:** all BCD, per nibble. No binary intermediate.

## Timing
- **Reset values:** `min_bcd`=00, `sec_bcd`=00, preset=00:00, state IDLE, and `tick_en`, `running`, `done`, `expired`, `load_err` all 0. Synchroniser and edge-detect flops are cleared to 0.
- **Tick latency:** a rising edge of `tick_in` produces an internal tick pulse SYNC_STAGES+1 cycles later. The count updates on the clock edge after that pulse.
- **Tick pulse width:** exactly one `mclk` cycle per `tick_in` rising edge, regardless of the high time.
- **Control latency:** `load`/`start`/`stop` take effect on the next edge. `running`, `tick_en` and `done` are registered and change together with the state.
- **`expired`:** asserted in the same cycle the count first shows 00:00 and DONE is entered.
- **Async reset mid-count:** all state is lost immediately and the count reads 00:00. `tick_en` drops asynchronously.

## Configuration
- **`MMSS_AUTORELOAD_EN` defined:** on reaching 00:00 in RUN, `expired` still pulses. In the next cycle the count reloads the stored preset and the state stays RUN; DONE is never entered from RUN. A preset of 00:00 still cannot be started.
- **Not defined:** the behaviour described above; the count stops in DONE.

## Structure
- **Package `timer_pkg`:**
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD constants: nibble max 9, seconds-tens max 5, seconds wrap value 8'h59
  - a BCD-validity function
- **Sub-module `sync_edge_det`:** SYNC_STAGES-flop synchroniser plus a rising-edge detector with a one-cycle pulse output. It is reusable for pushbutton inputs.
- **Top module:** the FSM and the BCD counter.

## Test plan
- **Reset value:** assert `reset`=0 mid-RUN → all outputs 0 immediately, count 00:00, IDLE after release.
- **Minute borrow:** load 01:00, start, apply 1 `tick_in` edge → count 00:59 at SYNC_STAGES+2 cycles after the edge; `tick_en`=1.
- **Expiry:** load 00:02, start, apply 2 edges → 00:00, `expired` high for exactly 1 cycle, `done`=1, `tick_en`=0; a further `start` is ignored.
- **Pause:** load 10:00, start, 3 edges, `stop`, 5 edges, `start`, 1 edge → 09:56.
- **Invalid load:** load `preset_ss`=8'h60 → `load_err` pulse, count unchanged. Load `preset_mm`=8'h1A → `load_err` pulse.
- **Simultaneous events:** `load` and `start` in one cycle → IDLE with the new preset. `stop` coincident with the tick pulse → no decrement.
- **Autoreload (`MMSS_AUTORELOAD_EN` build):** load 00:01, start, 1 edge → `expired` pulse, then count 00:01, `running` stays 1.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, BCD limits and preset validation for the MM:SS timer
package timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam logic [3:0] BCD_NIB_MAX  = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [7:0] SEC_WRAP     = 8'h59;

    function automatic logic bcd_valid(input logic [7:0] mm, input logic [7:0] ss);
        return (mm[7:4] <= BCD_NIB_MAX) && (mm[3:0] <= BCD_NIB_MAX) &&
               (ss[7:4] <= SEC_TENS_MAX) && (ss[3:0] <= BCD_NIB_MAX);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser followed by a registered one-cycle rising-edge pulse
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic pulse_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              pulse_q;

    // shift the async input through the chain, then pulse once per rising edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            prev_q  <= sync_q[STAGES-1];
            pulse_q <= sync_q[STAGES-1] & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/mmss_countdown.sv
// mmss_countdown: BCD MM:SS countdown timer driven by a synchronised 1 Hz square wave
// Optional feature: define MMSS_AUTORELOAD_EN to reload the preset and keep running at 00:00.
module mmss_countdown
    import timer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       load,
    input  logic       start,
    input  logic       stop,
    input  logic [7:0] preset_mm,
    input  logic [7:0] preset_ss,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       tick_en,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    state_t     state_q, state_d;
    logic [7:0] min_q, min_d, sec_q, sec_d;
    logic [7:0] pre_mm_q, pre_mm_d, pre_ss_q, pre_ss_d;
    logic       expired_q, expired_d, load_err_q, load_err_d;
    logic       running_q, done_q;
    logic       tick;
    logic [7:0] sec_dec, min_dec;
    logic       at_zero, at_one;
`ifdef MMSS_AUTORELOAD_EN
    logic       reload_q, reload_d;
`endif

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (mclk),
        .rst_n  (reset),
        .d_i    (tick_in),
        .pulse_o(tick)
    );

    assign at_zero = {min_q, sec_q} == 16'h0000;
    assign at_one  = {min_q, sec_q} == 16'h0001;

    // per-nibble BCD decrement; minutes only borrow when seconds wrap from 00
    always_comb begin
        sec_dec = (sec_q == 8'h00) ? SEC_WRAP :
                  (sec_q[3:0] == 4'd0) ? {sec_q[7:4] - 4'd1, BCD_NIB_MAX} :
                  {sec_q[7:4], sec_q[3:0] - 4'd1};
        min_dec = (sec_q != 8'h00 || min_q == 8'h00) ? min_q :
                  (min_q[3:0] == 4'd0) ? {min_q[7:4] - 4'd1, BCD_NIB_MAX} :
                  {min_q[7:4], min_q[3:0] - 4'd1};
    end

    // next state: load beats stop beats start beats tick
    always_comb begin
        state_d    = state_q;
        min_d      = min_q;
        sec_d      = sec_q;
        pre_mm_d   = pre_mm_q;
        pre_ss_d   = pre_ss_q;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
`ifdef MMSS_AUTORELOAD_EN
        reload_d   = 1'b0;
`endif
        if (load) begin
            if (bcd_valid(preset_mm, preset_ss)) begin
                pre_mm_d = preset_mm;
                pre_ss_d = preset_ss;
                min_d    = preset_mm;
                sec_d    = preset_ss;
                state_d  = IDLE;
            end else begin
                load_err_d = 1'b1;
            end
        end else begin
`ifdef MMSS_AUTORELOAD_EN
            if (reload_q) begin
                min_d = pre_mm_q;
                sec_d = pre_ss_q;
            end
`endif
            if (stop) begin
                if (state_q == RUN) state_d = PAUSE;
            end else if (start) begin
                if ((state_q == IDLE || state_q == PAUSE) && !at_zero) state_d = RUN;
`ifdef MMSS_AUTORELOAD_EN
            end else if (tick && state_q == RUN && !reload_q && !at_zero) begin
`else
            end else if (tick && state_q == RUN && !at_zero) begin
`endif
                min_d = min_dec;
                sec_d = sec_dec;
                if (at_one) begin
                    expired_d = 1'b1;
`ifdef MMSS_AUTORELOAD_EN
                    reload_d  = 1'b1;
`else
                    state_d   = DONE;
`endif
                end
            end
        end
    end

    // state, count, preset and registered status outputs
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            min_q      <= 8'h00;
            sec_q      <= 8'h00;
            pre_mm_q   <= 8'h00;
            pre_ss_q   <= 8'h00;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef MMSS_AUTORELOAD_EN
            reload_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            pre_mm_q   <= pre_mm_d;
            pre_ss_q   <= pre_ss_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
            running_q  <= state_d == RUN;
            done_q     <= state_d == DONE;
`ifdef MMSS_AUTORELOAD_EN
            reload_q   <= reload_d;
`endif
        end
    end

    assign min_bcd  = min_q;
    assign sec_bcd  = sec_q;
    assign running  = running_q;
    assign tick_en  = running_q;
    assign done     = done_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mmss_countdown.sv
// tb_mmss_countdown: directed self-checking bench for the MM:SS countdown timer
module tb_mmss_countdown;

    logic       mclk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_in = 1'b0;
    logic       load = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] preset_mm = 8'h00;
    logic [7:0] preset_ss = 8'h00;
    logic [7:0] min_bcd, sec_bcd;
    logic       tick_en, running, done, expired, load_err;

    int n_checks = 0;
    int n_fail = 0;

    mmss_countdown #(.SYNC_STAGES(2)) dut (
        .mclk     (mclk),
        .reset    (reset),
        .tick_in  (tick_in),
        .load     (load),
        .start    (start),
        .stop     (stop),
        .preset_mm(preset_mm),
        .preset_ss(preset_ss),
        .min_bcd  (min_bcd),
        .sec_bcd  (sec_bcd),
        .tick_en  (tick_en),
        .running  (running),
        .done     (done),
        .expired  (expired),
        .load_err (load_err)
    );

    always #5 mclk = ~mclk;

    task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
        @(negedge mclk);
        preset_mm = mm;
        preset_ss = ss;
        load = 1'b1;
        @(negedge mclk);
        load = 1'b0;
    endtask

    task automatic do_start();
        @(negedge mclk);
        start = 1'b1;
        @(negedge mclk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge mclk);
        stop = 1'b1;
        @(negedge mclk);
        stop = 1'b0;
    endtask

    task automatic tick_edge();
        @(negedge mclk);
        tick_in = 1'b1;
        repeat (4) @(negedge mclk);
        tick_in = 1'b0;
        repeat (4) @(negedge mclk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_count: got %h%h want 0000", min_bcd, sec_bcd);
        end
        n_checks++;
        if ({tick_en, running, done, expired, load_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {tick_en, running, done, expired, load_err});
        end
        repeat (2) @(negedge mclk);
        reset = 1'b1;
        @(negedge mclk);
    endtask

    task automatic test_minute_borrow();
        do_load(8'h01, 8'h00);
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0100) begin
            n_fail++;
            $display("FAIL borrow_load: got %h%h want 0100", min_bcd, sec_bcd);
        end
        do_start();
        n_checks++;
        if ({running, tick_en} !== 2'b11) begin
            n_fail++;
            $display("FAIL borrow_run: got %b want 11", {running, tick_en});
        end
        @(negedge mclk);
        tick_in = 1'b1;
        repeat (3) @(negedge mclk);
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0100) begin
            n_fail++;
            $display("FAIL borrow_early: got %h%h want 0100", min_bcd, sec_bcd);
        end
        @(negedge mclk);
        n_checks++;
        if ({min_bcd, sec_bcd, tick_en} !== {16'h0059, 1'b1}) begin
            n_fail++;
            $display("FAIL borrow_count: got %h%h en=%b want 0059 en=1", min_bcd, sec_bcd, tick_en);
        end
        tick_in = 1'b0;
        repeat (4) @(negedge mclk);
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0059) begin
            n_fail++;
            $display("FAIL borrow_single: got %h%h want 0059", min_bcd, sec_bcd);
        end
    endtask

`ifdef MMSS_AUTORELOAD_EN
    task automatic test_autoreload();
        do_load(8'h00, 8'h01);
        do_start();
        @(negedge mclk);
        tick_in = 1'b1;
        repeat (4) @(negedge mclk);
        n_checks++;
        if ({min_bcd, sec_bcd, expired, running} !== {16'h0000, 2'b11}) begin
            n_fail++;
            $display("FAIL reload_expire: got %h%h exp=%b run=%b want 0000 1 1", min_bcd, sec_bcd, expired, running);
        end
        @(negedge mclk);
        n_checks++;
        if ({min_bcd, sec_bcd, expired, running, done} !== {16'h0001, 3'b010}) begin
            n_fail++;
            $display("FAIL reload_count: got %h%h exp=%b run=%b done=%b want 0001 0 1 0", min_bcd, sec_bcd, expired, running, done);
        end
        tick_in = 1'b0;
        repeat (4) @(negedge mclk);
        do_stop();
    endtask
`else
    task automatic test_expiry();
        do_load(8'h00, 8'h02);
        do_start();
        tick_edge();
        n_checks++;
        if ({min_bcd, sec_bcd, expired} !== {16'h0001, 1'b0}) begin
            n_fail++;
            $display("FAIL expiry_first: got %h%h exp=%b want 0001 0", min_bcd, sec_bcd, expired);
        end
        @(negedge mclk);
        tick_in = 1'b1;
        repeat (4) @(negedge mclk);
        n_checks++;
        if ({min_bcd, sec_bcd, expired, done, tick_en, running} !== {16'h0000, 4'b1100}) begin
            n_fail++;
            $display("FAIL expiry_hit: got %h%h exp=%b done=%b en=%b run=%b want 0000 1 1 0 0",
                     min_bcd, sec_bcd, expired, done, tick_en, running);
        end
        @(negedge mclk);
        n_checks++;
        if ({expired, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL expiry_pulse: got exp=%b done=%b want 0 1", expired, done);
        end
        tick_in = 1'b0;
        do_start();
        n_checks++;
        if ({running, done, tick_en} !== 3'b010) begin
            n_fail++;
            $display("FAIL expiry_restart: got run=%b done=%b en=%b want 0 1 0", running, done, tick_en);
        end
    endtask
`endif

    task automatic test_pause();
        do_load(8'h10, 8'h00);
        do_start();
        repeat (3) tick_edge();
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0957) begin
            n_fail++;
            $display("FAIL pause_run: got %h%h want 0957", min_bcd, sec_bcd);
        end
        do_stop();
        n_checks++;
        if ({running, tick_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL pause_flags: got %b want 00", {running, tick_en});
        end
        repeat (5) tick_edge();
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0957) begin
            n_fail++;
            $display("FAIL pause_hold: got %h%h want 0957", min_bcd, sec_bcd);
        end
        do_start();
        tick_edge();
        n_checks++;
        if ({min_bcd, sec_bcd} !== 16'h0956) begin
            n_fail++;
            $display("FAIL pause_resume: got %h%h want 0956", min_bcd, sec_bcd);
        end
    endtask

    task automatic test_invalid_load();
        do_stop();
        do_load(8'h01, 8'h60);
        n_checks++;
        if ({load_err, min_bcd, sec_bcd} !== {1'b1, 16'h0956}) begin
            n_fail++;
            $display("FAIL bad_ss: got err=%b %h%h want 1 0956", load_err, min_bcd, sec_bcd);
        end
        @(negedge mclk);
        n_checks++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_ss_pulse: got %b want 0", load_err);
        end
        do_load(8'h1A, 8'h00);
        n_checks++;
        if ({load_err, min_bcd, sec_bcd} !== {1'b1, 16'h0956}) begin
            n_fail++;
            $display("FAIL bad_mm: got err=%b %h%h want 1 0956", load_err, min_bcd, sec_bcd);
        end
        do_start();
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_keeps_pause: got run=%b want 1", running);
        end
        do_stop();
    endtask

    task automatic test_simultaneous();
        @(negedge mclk);
        preset_mm = 8'h03;
        preset_ss = 8'h30;
        load = 1'b1;
        start = 1'b1;
        @(negedge mclk);
        load = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({running, min_bcd, sec_bcd} !== {1'b0, 16'h0330}) begin
            n_fail++;
            $display("FAIL load_start: got run=%b %h%h want 0 0330", running, min_bcd, sec_bcd);
        end
        do_start();
        @(negedge mclk);
        tick_in = 1'b1;
        repeat (3) @(negedge mclk);
        stop = 1'b1;
        @(negedge mclk);
        stop = 1'b0;
        n_checks++;
        if ({running, min_bcd, sec_bcd} !== {1'b0, 16'h0330}) begin
            n_fail++;
            $display("FAIL stop_tick: got run=%b %h%h want 0 0330", running, min_bcd, sec_bcd);
        end
        tick_in = 1'b0;
        repeat (4) @(negedge mclk);
        do_load(8'h00, 8'h00);
        do_start();
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_start: got run=%b want 0", running);
        end
    endtask

    task automatic test_reset_midrun();
        do_load(8'h05, 8'h00);
        do_start();
        tick_edge();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({min_bcd, sec_bcd, tick_en, running, done, expired, load_err} !== {16'h0000, 5'b0}) begin
            n_fail++;
            $display("FAIL midrun_reset: got %h%h flags=%b want 0000 00000",
                     min_bcd, sec_bcd, {tick_en, running, done, expired, load_err});
        end
        @(negedge mclk);
        reset = 1'b1;
        repeat (2) @(negedge mclk);
        n_checks++;
        if ({running, done, min_bcd, sec_bcd} !== {2'b00, 16'h0000}) begin
            n_fail++;
            $display("FAIL midrun_idle: got run=%b done=%b %h%h want 0 0 0000", running, done, min_bcd, sec_bcd);
        end
        do_start();
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_zero_start: got run=%b want 0", running);
        end
    endtask

    initial begin
        test_reset();
        test_minute_borrow();
`ifdef MMSS_AUTORELOAD_EN
        test_autoreload();
`else
        test_expiry();
`endif
        test_pause();
        test_invalid_load();
        test_simultaneous();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
